// File: rtl/counter_mod_k_updown_mode.sv
// Modulo-k up/down counter with WRAP, SATURATE and ONE-SHOT modes, registered tc/done.
// Optional wrap-event counter port o_wraps when COUNTER_MOD_K_WRAP_CNT_EN is defined.
module counter_mod_k_updown_mode #(
    parameter int unsigned N = 8
`ifdef COUNTER_MOD_K_WRAP_CNT_EN
    ,
    parameter int unsigned WRAP_W = 8
`endif
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [N-1:0] i_load_val,
    input  logic         i_en,
    input  logic         i_dir,
    input  logic [1:0]   i_mode,
    input  logic [N-1:0] i_k,
    output logic [N-1:0] o_count,
    output logic         o_tc,
    output logic         o_done
`ifdef COUNTER_MOD_K_WRAP_CNT_EN
    ,
    output logic [WRAP_W-1:0] o_wraps
`endif
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    state_t       state_q, state_d;
    logic [N-1:0] count_d;
    logic         tc_d;
    logic         done_d;
    logic [N-1:0] km1;
    logic         at_term;

    // k = 0 naturally wraps to all-ones, giving the full 2^N range
    assign km1     = N'(i_k - N'(1));
    assign at_term = i_dir ? (o_count >= km1) : (o_count == '0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_RUN;
            o_count <= '0;
            o_tc    <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state_q <= state_d;
            o_count <= count_d;
            o_tc    <= tc_d;
            o_done  <= done_d;
        end
    end

    // Next-state: clear > load > count; DONE only left via clr/load or mode change
    always_comb begin
        state_d = state_q;
        count_d = o_count;
        tc_d    = 1'b0;
        done_d  = o_done;
        if (i_clr) begin
            count_d = i_dir ? '0 : km1;
            state_d = ST_RUN;
            done_d  = 1'b0;
        end else if (i_load) begin
            count_d = (i_load_val > km1) ? km1 : i_load_val;
            state_d = ST_RUN;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (i_en) begin
                        if (!at_term) begin
                            count_d = i_dir ? N'(o_count + N'(1)) : N'(o_count - N'(1));
                        end else if (i_mode == MODE_SAT) begin
                            count_d = o_count;
                        end else if (i_mode == MODE_ONESHOT) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = i_dir ? '0 : km1;
                            tc_d    = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (i_mode != MODE_ONESHOT) begin
                        state_d = ST_RUN;
                        done_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

`ifdef COUNTER_MOD_K_WRAP_CNT_EN
    // Saturating count of terminal-count events; load does not clear it
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_wraps <= '0;
        end else if (i_clr) begin
            o_wraps <= '0;
        end else if (tc_d && (o_wraps != '1)) begin
            o_wraps <= WRAP_W'(o_wraps + WRAP_W'(1));
        end
    end
`endif

endmodule

// File: tb/tb_counter_mod_k_updown_mode.sv
// Directed self-checking bench for counter_mod_k_updown_mode (N=8 and N=4 instances).
module tb_counter_mod_k_updown_mode;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;
    logic       en = 1'b0;
    logic       dir = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [7:0] k = 8'd5;
    logic [3:0] k4 = 4'd0;
    logic [3:0] load_val4 = '0;

    logic [7:0] count;
    logic       tc, done;
    logic [3:0] count4;
    logic       tc4, done4;
`ifdef COUNTER_MOD_K_WRAP_CNT_EN
    logic [7:0] wraps, wraps4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_mod_k_updown_mode #(.N(8)) u0 (
        .i_clk(clk), .i_reset(rst), .i_clr(clr), .i_load(load), .i_load_val(load_val),
        .i_en(en), .i_dir(dir), .i_mode(mode), .i_k(k),
        .o_count(count), .o_tc(tc), .o_done(done)
`ifdef COUNTER_MOD_K_WRAP_CNT_EN
        , .o_wraps(wraps)
`endif
    );

    counter_mod_k_updown_mode #(.N(4)) u4 (
        .i_clk(clk), .i_reset(rst), .i_clr(clr), .i_load(load), .i_load_val(load_val4),
        .i_en(en), .i_dir(dir), .i_mode(mode), .i_k(k4),
        .o_count(count4), .o_tc(tc4), .o_done(done4)
`ifdef COUNTER_MOD_K_WRAP_CNT_EN
        , .o_wraps(wraps4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input int c, input int t, input int d);
        chk({tag, "_count"}, 32'(count), 32'(c));
        chk({tag, "_tc"}, 32'(tc), 32'(t));
        chk({tag, "_done"}, 32'(done), 32'(d));
    endtask

    initial begin
        int exp_dn[5];
        exp_dn = '{3, 2, 1, 0, 4};

        // reset
        #12;
        chk3("reset", 0, 0, 0);
        tick();
        rst = 1'b0;

        // WRAP up k=5
        en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk3($sformatf("wrap_up%0d", i), i % 5, (i == 5) ? 1 : 0, 0);
        end

        // WRAP down from clear
        clr = 1'b1; dir = 1'b0;
        tick();
        chk3("clr_down", 4, 0, 0);
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk3($sformatf("wrap_dn%0d", i), exp_dn[i], (i == 4) ? 1 : 0, 0);
        end

        // load clamping and priority over enable
        en = 1'b0; load = 1'b1; load_val = 8'd9;
        tick();
        chk3("load_clamp", 4, 0, 0);
        en = 1'b1; load_val = 8'd3;
        tick();
        chk3("load_en", 3, 0, 0);
        load = 1'b0; dir = 1'b1;
        tick();
        chk3("after_load", 4, 0, 0);
        k = 8'd8; load = 1'b1; load_val = 8'd7;
        tick();
        chk3("load7", 7, 0, 0);
        load = 1'b0; k = 8'd5;
        tick();
        chk3("out_of_range_up", 0, 1, 0);

        // ONE-SHOT k=3
        k = 8'd3; mode = 2'b10; clr = 1'b1;
        tick();
        chk3("os_clr", 0, 0, 0);
        clr = 1'b0;
        tick(); chk3("os1", 1, 0, 0);
        tick(); chk3("os2", 2, 0, 0);
        tick(); chk3("os_done", 2, 1, 1);
        tick(); chk3("os_hold", 2, 0, 1);
        tick(); chk3("os_hold2", 2, 0, 1);
        clr = 1'b1;
        tick(); chk3("os_clr2", 0, 0, 0);
        clr = 1'b0;
        tick(); tick(); tick();
        chk3("os_done2", 2, 1, 1);
        mode = 2'b00;
        tick(); chk3("os_leave", 2, 0, 0);
        tick(); chk3("os_leave_wrap", 0, 1, 0);

        // SATURATE down then up
        mode = 2'b01; dir = 1'b0; load = 1'b1; load_val = 8'd2;
        tick(); chk3("sat_load", 2, 0, 0);
        load = 1'b0;
        tick(); chk3("sat1", 1, 0, 0);
        tick(); chk3("sat0", 0, 0, 0);
        tick(); chk3("sat0b", 0, 0, 0);
        tick(); chk3("sat0c", 0, 0, 0);
        dir = 1'b1;
        tick(); chk3("sat_up1", 1, 0, 0);
        tick(); chk3("sat_up2", 2, 0, 0);

        // k=1: wrap every cycle
        mode = 2'b00; k = 8'd1; clr = 1'b1;
        tick(); chk3("k1_clr", 0, 0, 0);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk3($sformatf("k1_%0d", i), 0, 1, 0);
        end

        // N=4, k=0 full range; u0 keeps wrapping with k=1
        clr = 1'b1;
        tick();
        chk("n4_clr", 32'(count4), 32'd0);
`ifdef COUNTER_MOD_K_WRAP_CNT_EN
        chk("wraps_clr", 32'(wraps), 32'd0);
`endif
        clr = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("n4_count%0d", i), 32'(count4), 32'(i % 16));
            chk($sformatf("n4_tc%0d", i), 32'(tc4), (i == 16) ? 32'd1 : 32'd0);
        end
`ifdef COUNTER_MOD_K_WRAP_CNT_EN
        chk("wraps16", 32'(wraps), 32'd16);
`endif
        tick(); tick(); tick();
        chk("n4_mid", 32'(count4), 32'd3);
        chk("u0_tc_pre", 32'(tc), 32'd1);

        // async reset between edges
        rst = 1'b1;
        #2;
        chk("async_count4", 32'(count4), 32'd0);
        chk("async_tc", 32'(tc), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
